// File: rtl/qsram_edge_sequencer.sv
// rtl/qsram_edge_sequencer.sv - row-select and edge-pulse sequencer for a QSRAM cell array
// Host reads/writes become SETUP/PULSE/RECOVER sequences; periodic refresh takes strict priority.
module qsram_edge_sequencer #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int SETUP_CYCLES   = 1,
  parameter int PULSE_CYCLES   = 2,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [ADDR_W-1:0]      ReqAddr,
  input  logic [DATA_W-1:0]      ReqWData,
  output logic                   RspValid,
  output logic [DATA_W-1:0]      RspRData,
  output logic [2**ADDR_W-1:0]   RowSelect,
  output logic                   ReadEdge,
  output logic                   WriteEdge,
  output logic                   RefreshEdge,
  output logic [DATA_W-1:0]      ArrayInputData,
  input  logic [DATA_W-1:0]      ArrayOutputData,
  output logic                   RefreshOverrun
);

  localparam int ROWS    = 2**ADDR_W;
  localparam int CNT_MAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TMR_W   = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, RECOVER} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_REFRESH} op_t;

  state_t            state, nState;
  op_t               op, nOp;
  logic [ADDR_W-1:0] curRow, nRow, refreshRow;
  logic [DATA_W-1:0] curData, nData;
  logic [CNT_W-1:0]  phaseCnt, nCnt;
  logic [TMR_W-1:0]  refreshTimer;
  logic              refreshPending, nPending, timerExpire, refreshDone;

  assign timerExpire = (refreshTimer == '0);
  assign refreshDone = (state == RECOVER) && (op == OP_REFRESH);

  // A timer expiry in the same cycle that RECOVER retires a refresh keeps it pending.
  always_comb begin
    nPending = refreshPending;
    if (timerExpire)
      nPending = 1'b1;
    else if (refreshDone)
      nPending = 1'b0;
  end

  always_comb begin
    nState = state;
    nOp    = op;
    nRow   = curRow;
    nData  = curData;
    nCnt   = phaseCnt;
    case (state)
      IDLE: begin
        if (refreshPending) begin
          nState = SETUP;
          nOp    = OP_REFRESH;
          nRow   = refreshRow;
          nData  = '0;
          nCnt   = CNT_W'(SETUP_CYCLES - 1);
        end else if (ReqValid && ReqReady) begin
          nState = SETUP;
          nOp    = ReqWrite ? OP_WRITE : OP_READ;
          nRow   = ReqAddr;
          nData  = ReqWrite ? ReqWData : '0;
          nCnt   = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (phaseCnt == '0) begin
          nState = PULSE;
          nCnt   = CNT_W'(PULSE_CYCLES - 1);
        end else begin
          nCnt = phaseCnt - CNT_W'(1);
        end
      end
      PULSE: begin
        if (phaseCnt == '0)
          nState = RECOVER;
        else
          nCnt = phaseCnt - CNT_W'(1);
      end
      default: nState = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state          <= IDLE;
      op             <= OP_READ;
      curRow         <= '0;
      curData        <= '0;
      phaseCnt       <= '0;
      refreshTimer   <= TMR_W'(REFRESH_PERIOD - 1);
      refreshRow     <= '0;
      refreshPending <= 1'b0;
      RefreshOverrun <= 1'b0;
      ReqReady       <= 1'b0;
      RspValid       <= 1'b0;
      RspRData       <= '0;
      RowSelect      <= '0;
      ReadEdge       <= 1'b0;
      WriteEdge      <= 1'b0;
      RefreshEdge    <= 1'b0;
      ArrayInputData <= '0;
    end else begin
      state          <= nState;
      op             <= nOp;
      curRow         <= nRow;
      curData        <= nData;
      phaseCnt       <= nCnt;
      refreshTimer   <= timerExpire ? TMR_W'(REFRESH_PERIOD - 1) : refreshTimer - TMR_W'(1);
      refreshPending <= nPending;
      if (timerExpire && refreshPending)
        RefreshOverrun <= 1'b1;
      if (refreshDone)
        refreshRow <= refreshRow + ADDR_W'(1);
      ReqReady       <= (nState == IDLE) && !nPending;
      RspValid       <= (nState == RECOVER) && (nOp == OP_READ);
      if ((state == PULSE) && (phaseCnt == '0) && (op == OP_READ))
        RspRData <= ArrayOutputData;
      RowSelect      <= (nState != IDLE) ? (ROWS'(1) << nRow) : '0;
      ArrayInputData <= (nState != IDLE) ? nData : '0;
      ReadEdge       <= (nState == PULSE) && (nOp == OP_READ);
      WriteEdge      <= (nState == PULSE) && (nOp == OP_WRITE);
      RefreshEdge    <= (nState == PULSE) && (nOp == OP_REFRESH);
    end
  end

endmodule

// File: tb/tb_qsram_edge_sequencer.sv
// tb/tb_qsram_edge_sequencer.sv - directed bench for qsram_edge_sequencer
// Second instance uses a short refresh period with long pulses to provoke overrun.
module tb_qsram_edge_sequencer;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        reqValid, reqWrite, reqReady;
  logic [3:0]  reqAddr;
  logic [7:0]  reqWData, rspRData, arrayInputData, arrayOutputData;
  logic        rspValid, readEdge, writeEdge, refreshEdge, refreshOverrun;
  logic [15:0] rowSelect;

  logic        reqValid5, reqReady5, rspValid5, readEdge5, writeEdge5, refreshEdge5, refreshOverrun5;
  logic [7:0]  rspRData5, arrayInputData5;
  logic [15:0] rowSelect5;
  logic [7:0]  zeroData = 8'h00;
  logic [3:0]  addr5 = 4'h2;

  int cyc, numChecks, numFailures, atCyc;

  always #5 Clock = ~Clock;

  qsram_edge_sequencer u_dut (
    .Clock(Clock), .ResetN(ResetN), .ReqValid(reqValid), .ReqReady(reqReady),
    .ReqWrite(reqWrite), .ReqAddr(reqAddr), .ReqWData(reqWData),
    .RspValid(rspValid), .RspRData(rspRData), .RowSelect(rowSelect),
    .ReadEdge(readEdge), .WriteEdge(writeEdge), .RefreshEdge(refreshEdge),
    .ArrayInputData(arrayInputData), .ArrayOutputData(arrayOutputData),
    .RefreshOverrun(refreshOverrun)
  );

  qsram_edge_sequencer #(.REFRESH_PERIOD(8), .PULSE_CYCLES(4)) u_dut5 (
    .Clock(Clock), .ResetN(ResetN), .ReqValid(reqValid5), .ReqReady(reqReady5),
    .ReqWrite(1'b0), .ReqAddr(addr5), .ReqWData(zeroData),
    .RspValid(rspValid5), .RspRData(rspRData5), .RowSelect(rowSelect5),
    .ReadEdge(readEdge5), .WriteEdge(writeEdge5), .RefreshEdge(refreshEdge5),
    .ArrayInputData(arrayInputData5), .ArrayOutputData(zeroData),
    .RefreshOverrun(refreshOverrun5)
  );

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFailures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step;
    @(negedge Clock);
    cyc++;
  endtask

  task automatic waitRefreshRise(output int foundAt);
    logic prev;
    prev = refreshEdge;
    foundAt = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (refreshEdge && !prev) begin
        foundAt = cyc;
        break;
      end
      prev = refreshEdge;
    end
    if (foundAt < 0) checkValue("refresh_timeout", 0, 1);
  endtask

  initial begin
    numChecks = 0; numFailures = 0; cyc = 0;
    reqValid = 0; reqWrite = 0; reqAddr = 0; reqWData = 0; arrayOutputData = 0;
    reqValid5 = 1'b1;
    repeat (3) @(negedge Clock);
    checkValue("rst_ready", reqReady, 0);
    checkValue("rst_rowsel", rowSelect, 0);
    checkValue("rst_edges", {readEdge, writeEdge, refreshEdge}, 0);
    checkValue("rst_rsp", {rspValid, rspRData}, 0);
    checkValue("rst_overrun", refreshOverrun, 0);
    ResetN = 1'b1;
    cyc = 0;

    // write 0xA5 to row 3
    step();
    checkValue("ready_after_rst", reqReady, 1);
    reqValid = 1; reqWrite = 1; reqAddr = 3; reqWData = 8'hA5;
    step();
    reqValid = 0;
    checkValue("wr_setup_rowsel", rowSelect, 16'h0008);
    checkValue("wr_setup_edge", writeEdge, 0);
    checkValue("wr_setup_data", arrayInputData, 8'hA5);
    checkValue("wr_setup_ready", reqReady, 0);
    step();
    checkValue("wr_pulse1_edge", {readEdge, writeEdge, refreshEdge}, 3'b010);
    checkValue("wr_pulse1_rowsel", rowSelect, 16'h0008);
    step();
    checkValue("wr_pulse2_edge", writeEdge, 1);
    checkValue("wr_pulse2_data", arrayInputData, 8'hA5);
    step();
    checkValue("wr_recover_edge", writeEdge, 0);
    checkValue("wr_recover_rsp", rspValid, 0);
    checkValue("wr_recover_rowsel", rowSelect, 16'h0008);
    step();
    checkValue("wr_idle_ready", reqReady, 1);
    checkValue("wr_idle_rowsel", rowSelect, 0);

    // read row 3, array returns 0x5A
    reqValid = 1; reqWrite = 0; reqAddr = 3; arrayOutputData = 8'h5A;
    step();
    reqValid = 0;
    checkValue("rd_setup_rowsel", rowSelect, 16'h0008);
    checkValue("rd_setup_edge", readEdge, 0);
    checkValue("rd_setup_data", arrayInputData, 0);
    step();
    checkValue("rd_pulse1_edge", {readEdge, writeEdge, refreshEdge}, 3'b100);
    step();
    checkValue("rd_pulse2_edge", readEdge, 1);
    checkValue("rd_pulse2_rsp", rspValid, 0);
    step();
    arrayOutputData = 8'h00;
    checkValue("rd_recover_rsp", rspValid, 1);
    checkValue("rd_recover_data", rspRData, 8'h5A);
    checkValue("rd_recover_edge", readEdge, 0);
    step();
    checkValue("rd_after_rsp", rspValid, 0);
    checkValue("rd_hold_data", rspRData, 8'h5A);

    // short-period instance: overrun appears in cycle 24
    while (cyc < 23) step();
    checkValue("ovr5_before", refreshOverrun5, 0);
    step();
    checkValue("ovr5_rise", refreshOverrun5, 1);

    // request held while refresh becomes pending
    while (cyc < 63) step();
    checkValue("pre_refresh_ready", reqReady, 1);
    step();
    checkValue("pending_ready", reqReady, 0);
    reqValid = 1; reqWrite = 1; reqAddr = 5; reqWData = 8'h3C;
    checkValue("ovr5_sticky_a", refreshOverrun5, 1);
    step();
    checkValue("ref_setup_rowsel", rowSelect, 16'h0001);
    checkValue("ref_setup_edge", refreshEdge, 0);
    step();
    checkValue("ref_pulse_edge", {readEdge, writeEdge, refreshEdge}, 3'b001);
    checkValue("ref_pulse_rowsel", rowSelect, 16'h0001);
    step();
    checkValue("ref_pulse2_edge", refreshEdge, 1);
    step();
    checkValue("ref_recover_edge", refreshEdge, 0);
    checkValue("ref_recover_ready", reqReady, 0);
    checkValue("ref_recover_rsp", rspValid, 0);
    step();
    checkValue("post_ref_ready", reqReady, 1);
    step();
    reqValid = 0;
    checkValue("held_req_rowsel", rowSelect, 16'h0020);
    checkValue("held_req_data", arrayInputData, 8'h3C);
    checkValue("no_overrun", refreshOverrun, 0);
    step();
    checkValue("held_req_edge", writeEdge, 1);

    // idle refresh walk across all rows and wrap
    for (int k = 1; k <= 16; k++) begin
      waitRefreshRise(atCyc);
      checkValue("refresh_cycle", atCyc, 66 + 64 * k);
      checkValue("refresh_row", rowSelect, 32'(1) << (k % 16));
    end
    checkValue("no_overrun_idle", refreshOverrun, 0);
    checkValue("ovr5_sticky_b", refreshOverrun5, 1);

    // async reset in the middle of a read pulse
    for (int i = 0; i < 20; i++) begin
      if (reqReady) break;
      step();
    end
    checkValue("ready_before_abort", reqReady, 1);
    reqValid = 1; reqWrite = 0; reqAddr = 9; arrayOutputData = 8'h77;
    step();
    reqValid = 0;
    step();
    checkValue("abort_pulse_edge", readEdge, 1);
    checkValue("abort_pulse_rowsel", rowSelect, 16'h0200);
    ResetN = 1'b0;
    #1;
    checkValue("abort_edge_drop", readEdge, 0);
    checkValue("abort_rowsel_drop", rowSelect, 0);
    checkValue("abort_ready", reqReady, 0);
    step();
    checkValue("abort_no_rsp", rspValid, 0);
    checkValue("abort_rdata", rspRData, 0);
    checkValue("ovr5_cleared", refreshOverrun5, 0);
    step();
    ResetN = 1'b1;
    cyc = 0;
    step();
    checkValue("release_ready", reqReady, 1);
    checkValue("release_no_rsp", rspValid, 0);
    waitRefreshRise(atCyc);
    checkValue("timer_restart", atCyc, 66);
    checkValue("timer_restart_row", rowSelect, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
    $finish;
  end

endmodule
